// File: rtl/hamm_pkg.sv
// Shared types and constants for the SEC-DED Hamming(16,11) decoder.
// Holds the control FSM state type, the status flag encodings, the codeword
// bit positions and the syndrome masks. Helpers build the two output bytes
// of a decoded word.
package hamm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StDecode,
    StWrLo,
    StWrHi,
    StDone
  } state_e;

  localparam logic [1:0] FLAG_OK  = 2'b00;  // clean word
  localparam logic [1:0] FLAG_SEC = 2'b01;  // single error corrected
  localparam logic [1:0] FLAG_DED = 2'b10;  // double error detected, left as is

  // Parity bit positions; p0 is the overall parity bit.
  localparam int unsigned POS_P0 = 0;
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

  // Lowest position of each contiguous data-bit run.
  localparam int unsigned POS_D1 = 3;   // d1
  localparam int unsigned POS_D2 = 5;   // d4..d2 at 7..5
  localparam int unsigned POS_D5 = 9;   // d8..d5 at 12..9
  localparam int unsigned POS_D9 = 13;  // d11..d9 at 15..13

  // SYN_MASK[j] selects codeword bits k in 1..15 whose index has bit j set.
  localparam logic [3:0][15:0] SYN_MASK = {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA};

  // Low output byte: d8..d1.
  function automatic logic [7:0] data_lo(input logic [15:0] cw);
    return {cw[POS_D5+3:POS_D5], cw[POS_D2+2:POS_D2], cw[POS_D1]};
  endfunction

  // High output byte: status flag, three zeros, d11..d9.
  function automatic logic [7:0] data_hi(input logic [15:0] cw, input logic [1:0] flag);
    return {flag, 3'b000, cw[POS_D9+2:POS_D9]};
  endfunction

endpackage

// File: rtl/hamm_syndrome.sv
// Combinational SEC-DED check of one 16-bit codeword.
// Ports:
//   cw     in  raw codeword
//   cw_fix out codeword with a single-bit error flipped back (unchanged otherwise)
//   flag   out FLAG_OK / FLAG_SEC / FLAG_DED
//   syn    out 4-bit syndrome (position of a single error)
module hamm_syndrome
  import hamm_pkg::*;
(
  input  logic [15:0] cw,
  output logic [15:0] cw_fix,
  output logic [1:0]  flag,
  output logic [3:0]  syn
);

  logic parity;

  always_comb begin
    syn = '0;
    for (int j = 0; j < 4; j++) begin
      syn[j] = ^(cw & SYN_MASK[j]);
    end
    parity = ^cw;
    cw_fix = cw;
    flag   = FLAG_OK;
    if (parity) begin
      // Odd overall parity means one flipped bit; syndrome 0 points at p0.
      cw_fix = cw ^ (16'b1 << syn);
      flag   = FLAG_SEC;
    end else if (syn != 4'd0) begin
      flag = FLAG_DED;
    end
  end

endmodule

// File: rtl/hamm_decoder.sv
// Block decoder: reads NUM_WORDS Hamming(16,11) codewords from a byte memory,
// corrects/flags them and writes two result bytes per word.
// Optional macro HAMM_DEC_STATS_EN adds per-run error counters.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req                start request, honoured only in idle or done
//   done               high while the run is finished
//   mem_addr/mem_rdata byte address and combinational read data
//   mem_wdata/mem_we   write data and strobe
//   err1_cnt/err2_cnt  (HAMM_DEC_STATS_EN) corrected / uncorrectable word counts
module hamm_decoder
  import hamm_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned DST_BASE  = 0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef HAMM_DEC_STATS_EN
  output logic [4:0] err1_cnt,
  output logic [4:0] err2_cnt,
`endif
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we
);

  localparam int unsigned   IW       = $clog2(NUM_WORDS + 1);
  localparam logic [7:0]    SRC      = 8'(SRC_BASE);
  localparam logic [7:0]    DST      = 8'(DST_BASE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  state_e        state;
  logic [IW-1:0] idx;
  logic [7:0]    lo_q, hi_q, wdata_hi_q;
  logic [15:0]   fix;
  logic [1:0]    flag;
  logic [3:0]    syn;

  // Byte offset of word w, modulo 256.
  function automatic logic [7:0] word_off(input logic [IW-1:0] w);
    return 8'(w) << 1;
  endfunction

  hamm_syndrome u_syndrome (
    .cw     ({hi_q, lo_q}),
    .cw_fix (fix),
    .flag   (flag),
    .syn    (syn)
  );

  // Syndrome and parity bits carry no payload once the word is corrected.
  logic unused_bits;
  assign unused_bits = ^{syn, fix[POS_P8], fix[POS_P4], fix[POS_P2], fix[POS_P1], fix[POS_P0]};

  // Memory address/strobe are registered, so each is set on the edge that
  // enters the state which uses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      idx        <= '0;
      done       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      wdata_hi_q <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (req) begin
            state    <= StRdLo;
            idx      <= '0;
            done     <= 1'b0;
            mem_addr <= SRC;
          end else begin
            // done follows the state one cycle late, dropping at once on restart.
            done <= (state == StDone);
          end
        end
        StRdLo: begin
          lo_q     <= mem_rdata;
          mem_addr <= mem_addr + 8'd1;
          state    <= StRdHi;
        end
        StRdHi: begin
          hi_q  <= mem_rdata;
          state <= StDecode;
        end
        StDecode: begin
          wdata_hi_q <= data_hi(fix, flag);
          mem_addr   <= DST + word_off(idx);
          mem_wdata  <= data_lo(fix);
          mem_we     <= 1'b1;
          state      <= StWrLo;
        end
        StWrLo: begin
          mem_addr  <= mem_addr + 8'd1;
          mem_wdata <= wdata_hi_q;
          state     <= StWrHi;
        end
        StWrHi: begin
          mem_we <= 1'b0;
          if (idx < LAST_IDX) begin
            idx      <= idx + 1'b1;
            mem_addr <= SRC + word_off(idx + 1'b1);
            state    <= StRdLo;
          end else begin
            state <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef HAMM_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else if ((state == StIdle || state == StDone) && req) begin
      err1_cnt <= '0;
      err2_cnt <= '0;
    end else if (state == StDecode) begin
      if (flag == FLAG_SEC && err1_cnt != 5'd31) err1_cnt <= err1_cnt + 5'd1;
      if (flag == FLAG_DED && err2_cnt != 5'd31) err2_cnt <= err2_cnt + 5'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hamm_decoder.sv
// Self-checking bench for hamm_decoder: directed codewords, random encoded
// words against a reference decoder, latency, restart from done and mid-run reset.
module tb_hamm_decoder;

  logic clk = 1'b0;
  logic reset, req, req1, load;
  always #5 clk = ~clk;

  logic       done_a, we_a, done_b, we_b;
  logic [7:0] addr_a, rdata_a, wdata_a, addr_b, rdata_b, wdata_b;
`ifdef HAMM_DEC_STATS_EN
  logic [4:0] e1_a, e2_a, e1_b, e2_b;
`endif

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] img_a [256];
  logic [7:0] img_b [256];

  assign rdata_a = mem_a[addr_a];
  assign rdata_b = mem_b[addr_b];

  always @(posedge clk) begin
    if (load) begin
      mem_a <= img_a;
      mem_b <= img_b;
    end else begin
      if (we_a) mem_a[addr_a] <= wdata_a;
      if (we_b) mem_b[addr_b] <= wdata_b;
    end
  end

  hamm_decoder dut (
    .clk       (clk),
    .reset     (reset),
`ifdef HAMM_DEC_STATS_EN
    .err1_cnt  (e1_a),
    .err2_cnt  (e2_a),
`endif
    .req       (req),
    .done      (done_a),
    .mem_addr  (addr_a),
    .mem_rdata (rdata_a),
    .mem_wdata (wdata_a),
    .mem_we    (we_a)
  );

  hamm_decoder #(.NUM_WORDS(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
`ifdef HAMM_DEC_STATS_EN
    .err1_cnt  (e1_b),
    .err2_cnt  (e2_b),
`endif
    .req       (req1),
    .done      (done_b),
    .mem_addr  (addr_b),
    .mem_rdata (rdata_b),
    .mem_wdata (wdata_b),
    .mem_we    (we_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: syndrome as XOR of the indices of set bits 1..15.
  function automatic logic [15:0] ref_decode(input logic [15:0] cw_in, output logic [1:0] fl);
    logic [15:0] cw;
    logic [3:0]  s;
    logic        p;
    cw = cw_in;
    s  = '0;
    for (int k = 1; k < 16; k++) if (cw[k]) s ^= 4'(k);
    p  = ^cw;
    fl = 2'b00;
    if (p) begin
      cw[s] = ~cw[s];
      fl    = 2'b01;
    end else if (s != 0) begin
      fl = 2'b10;
    end
    return {fl, 3'b000, cw[15:13], cw[12:9], cw[7:5], cw[3]};
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    int          dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] cw;
    logic [3:0]  s;
    cw = '0;
    for (int i = 0; i < 11; i++) cw[dpos[i]] = d[i];
    s = '0;
    for (int k = 1; k < 16; k++) if (cw[k]) s ^= 4'(k);
    for (int j = 0; j < 4; j++) if (s[j]) cw[1 << j] = 1'b1;
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] cw;
    int          nf, b1, b2;
    cw = encode(11'($urandom));
    nf = $urandom_range(0, 2);
    b1 = $urandom_range(0, 15);
    b2 = (b1 + $urandom_range(1, 15)) % 16;
    if (nf >= 1) cw[b1] = ~cw[b1];
    if (nf == 2) cw[b2] = ~cw[b2];
    return cw;
  endfunction

  logic [15:0] src [15];
  logic [15:0] exp_w [15];
  int          exp_e1, exp_e2;

  // Fill image A with words from src[], dest area with a sentinel.
  task automatic fill_a();
    logic [1:0] fl;
    exp_e1 = 0;
    exp_e2 = 0;
    for (int a = 0; a < 256; a++) img_a[a] = 8'hEE;
    for (int i = 0; i < 15; i++) begin
      img_a[30 + 2 * i] = src[i][7:0];
      img_a[31 + 2 * i] = src[i][15:8];
      exp_w[i] = ref_decode(src[i], fl);
      if (fl == 2'b01) exp_e1++;
      if (fl == 2'b10) exp_e2++;
    end
  endtask

  task automatic load_mems();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic run_a(input string tag, input bit poke);
    int cyc;
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    check({tag, " done_low_after_start"}, 32'(done_a), 0);
    cyc = 0;
    while (!done_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req = poke && (cyc == 10);
    end
    req = 1'b0;
    check({tag, " latency"}, cyc, 76);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("%s lo%0d", tag, i), 32'(mem_a[2 * i]), 32'(exp_w[i][7:0]));
      check($sformatf("%s hi%0d", tag, i), 32'(mem_a[2 * i + 1]), 32'(exp_w[i][15:8]));
    end
`ifdef HAMM_DEC_STATS_EN
    check({tag, " err1_cnt"}, 32'(e1_a), exp_e1);
    check({tag, " err2_cnt"}, 32'(e2_a), exp_e2);
`endif
  endtask

  initial begin
    int          cyc, we_seen, bad;
    logic [15:0] dir [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h0020, 16'h0001, 16'h0003};
    logic [15:0] dexp [6] = '{16'h0000, 16'h07FF, 16'h47FF, 16'h4000, 16'h4000, 16'h8000};
    reset = 1'b1;
    req   = 1'b0;
    req1  = 1'b0;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst done", 32'(done_a), 0);
    check("rst we", 32'(we_a), 0);
    check("rst addr", 32'(addr_a), 0);
    check("rst wdata", 32'(wdata_a), 0);
    reset = 1'b0;

    // Single-word instance: all-zero codeword, done after 6 cycles.
    for (int a = 0; a < 256; a++) img_b[a] = 8'h55;
    img_b[30] = 8'h00;
    img_b[31] = 8'h00;
    for (int i = 0; i < 15; i++) src[i] = dir[i % 6];
    fill_a();
    load_mems();
    @(negedge clk) req1 = 1'b1;
    @(negedge clk) req1 = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("n1 latency", cyc, 6);
    check("n1 byte0", 32'(mem_b[0]), 0);
    check("n1 byte1", 32'(mem_b[1]), 0);

    // Run A: directed words with hand-computed results, then random; req poked mid-run.
    for (int i = 6; i < 15; i++) src[i] = rand_word();
    fill_a();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("dir exp%0d", i), 32'(exp_w[i]), 32'(dexp[i]));
    end
    load_mems();
    run_a("A", 1'b1);

    // Run B: 15 random words, restarted directly from done.
    for (int i = 0; i < 15; i++) src[i] = rand_word();
    fill_a();
    load_mems();
    check("B done_before", 32'(done_a), 1);
    run_a("B", 1'b0);

    // Run C: reset lands after word 3 is fully written.
    for (int i = 0; i < 15; i++) src[i] = rand_word();
    fill_a();
    load_mems();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("C rst done", 32'(done_a), 0);
    check("C rst we", 32'(we_a), 0);
    check("C rst addr", 32'(addr_a), 0);
    check("C rst wdata", 32'(wdata_a), 0);
`ifdef HAMM_DEC_STATS_EN
    check("C rst err1", 32'(e1_a), 0);
    check("C rst err2", 32'(e2_a), 0);
`endif
    reset = 1'b0;
    we_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (we_a) we_seen++;
    end
    check("C no_writes_after_reset", we_seen, 0);
    check("C still_idle", 32'(done_a), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("C lo%0d", i), 32'(mem_a[2 * i]), 32'(exp_w[i][7:0]));
      check($sformatf("C hi%0d", i), 32'(mem_a[2 * i + 1]), 32'(exp_w[i][15:8]));
    end
    bad = 0;
    for (int a = 8; a < 30; a++) if (mem_a[a] != 8'hEE) bad++;
    check("C untouched_bytes", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamm_decoder.md
HAMM_DECODER -- requirements
Module: hamm_decoder

Interface
- REQ-001 Parameter NUM_WORDS, default 15, number of 16-bit codewords processed per request.
- REQ-002 Parameter SRC_BASE, default 30, byte address of the first encoded word's low byte.
- REQ-003 Parameter DST_BASE, default 0, byte address of the first decoded word's low byte.
- REQ-004 clk  input  1  single clock; all state updates on its rising edge.
- REQ-005 reset  input  1  synchronous, active-high reset.
- REQ-006 req  input  1  start request; sampled only in IDLE or DONE.
- REQ-007 done  output  1  high while in DONE.
- REQ-008 mem_addr  output  8  data-memory byte address.
- REQ-009 mem_rdata  input  8  memory read data, combinational from mem_addr in the same cycle.
- REQ-010 mem_wdata  output  8  memory write data.
- REQ-011 mem_we  output  1  write strobe; memory writes on the clk edge when high.

Function
- REQ-012 Word i is read from bytes SRC_BASE+2i (lo) and SRC_BASE+2i+1 (hi); cw = {hi,lo}.
- REQ-013 Codeword layout is bit15..0 = {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
- REQ-014 Syndrome s[3:0]: s[j] = XOR of cw bits k in 1..15 with k[j]=1; P = XOR of all 16 cw bits.
- REQ-015 Status: s=0,P=0 -> flag 2'b00; P=1 -> flag 2'b01 and cw bit s inverted (s=0 inverts p0); s!=0,P=0 -> flag 2'b10 with cw left uncorrected.
- REQ-016 Output lo byte = d[8:1] = {cw[12:9], cw[7:5], cw[3]}; hi byte = {flag, 3'b000, cw[15:13]}, both taken from the corrected cw.
- REQ-017 Output lo goes to DST_BASE+2i and hi to DST_BASE+2i+1.
- REQ-018 FSM states: IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE; each state lasts one cycle except IDLE and DONE.
- REQ-019 Transitions:
  - IDLE or DONE with req=1 -> RD_LO, i=0.
  - RD_LO -> RD_HI -> DECODE -> WR_LO -> WR_HI.
  - WR_HI -> RD_LO with i+1 when i<NUM_WORDS-1, else DONE.
- REQ-020 RD_LO and RD_HI capture mem_rdata into registers; DECODE registers the corrected word and flag; WR_LO and WR_HI assert mem_we.
- REQ-021 Latency: done rises exactly 5*NUM_WORDS+1 cycles after the edge that samples req=1.
- REQ-022 req is ignored in every state other than IDLE and DONE.
- REQ-023 In DONE, req=1 restarts at i=0 and done falls on the next cycle.
- REQ-024 mem_we is high only in WR_LO/WR_HI; mem_addr and mem_wdata are don't-care when mem_we=0 and not reading.
- REQ-025 Word index counter width is $clog2(NUM_WORDS+1); address arithmetic is 8-bit modulo 256.

Reset
- REQ-026 reset=1 forces IDLE, i=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0 on the next edge.
- REQ-027 Reset overrides req; a reset mid-run aborts, no further writes occur, and completed writes are not undone.

Configuration
- REQ-028 Macro HAMM_DEC_STATS_EN defined: adds outputs err1_cnt[4:0] and err2_cnt[4:0], counting flag 01 and flag 10 words in the current run.
- REQ-029 Both counters clear on reset and on the start sample, saturate at 31, and hold in DONE.
- REQ-030 Macro undefined: the ports and counters are absent and behaviour is otherwise identical.

Structure
- REQ-031 Package hamm_pkg holds the state enum, flag constants (FLAG_OK=2'b00, FLAG_SEC=2'b01, FLAG_DED=2'b10) and codeword bit-position constants.
- REQ-032 Sub-module hamm_syndrome is combinational: cw[15:0] in; corrected cw, flag[1:0] and s[3:0] out. It is instantiated once.

Verification
- REQ-033 cw=0x0000 at bytes 30/31, NUM_WORDS=1, req pulse -> byte0=0x00, byte1=0x00, done after 6 cycles.
- REQ-034 cw=0xFFFF -> lo=0xFF, hi=0x07; cw=0x7FFF (bit15 flipped) -> lo=0xFF, hi=0x47.
- REQ-035 cw=0x0020 (single error at bit5) -> lo=0x00, hi=0x40; cw=0x0001 (p0 flipped) -> lo=0x00, hi=0x40.
- REQ-036 cw=0x0003 (double error) -> lo=0x00, hi=0x80.
- REQ-037 15 random encoded words with 0/1/2 random flips, compared against a reference model -> all 30 output bytes match and done asserts at cycle 76.
- REQ-038 Assert reset at cycle 20 of a 15-word run -> IDLE next cycle, mem_we stays 0 afterwards, and words 0-3 remain written.
